// File: rtl/definitions.sv
// Shared types and constants for the fetch stage and its Decode-side consumer.
package definitions;

    typedef logic [31:0] ProgramCounter;
    typedef logic [31:0] Instr;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } FetchState;

    typedef struct packed {
        logic          stall;
        logic          redirect_valid;
        ProgramCounter redirect_pc;
    } F_control;

    // Field order matches the Decode stage's D_input.
    typedef struct packed {
        logic          valid;
        Instr          instr;
        ProgramCounter pc;
    } F_output;

    localparam Instr NOP = 32'h0000_0000;

    function automatic ProgramCounter align_pc(input ProgramCounter pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register that parks a response while Decode is stalled.
module fetch_hold_buffer
    import definitions::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic drain_i,
    input  logic clear_i,
    input  Instr data_i,
    output logic valid_o,
    output Instr data_o
);

    logic valid_q, valid_d;
    Instr data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs a single-outstanding request/grant/response
// fetch to imem and feeds Decode through a registered F/D register.
module fetch_stage
    import definitions::*;
#(
    parameter ProgramCounter RESET_PC  = 32'h0000_0000,
    parameter Instr          NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    F_control      ctrl;
    FetchState     state_q, state_d;
    ProgramCounter pc_q, pc_d, pc_next;
    logic          drop_q, drop_d;
    F_output       fd_q, fd_d;
    logic          can_load;
    logic          hb_load, hb_drain, hb_clear, hb_valid;
    Instr          hb_data;

    assign ctrl     = '{stall: stall, redirect_valid: redirect_valid, redirect_pc: redirect_pc};
    assign pc_next  = pc_q + 32'd4;
    assign can_load = !ctrl.stall || !fd_q.valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        hb_clear = 1'b0;
        if (ctrl.stall && fd_q.valid) fd_d = fd_q;
        else                          fd_d = '{valid: 1'b0, instr: NOP_INSTR, pc: fd_q.pc};

        if (ctrl.redirect_valid) begin
            // A grant or an unanswered request here leaves a response in flight; drop marks it stale.
            pc_d     = align_pc(ctrl.redirect_pc);
            fd_d     = '{valid: 1'b0, instr: NOP_INSTR, pc: fd_q.pc};
            hb_clear = 1'b1;
            drop_d   = 1'b0;
            state_d  = REQ;
            if (state_q == REQ && imem_gnt) begin
                state_d = WAIT;
                drop_d  = 1'b1;
            end else if (state_q == WAIT && !imem_rvalid) begin
                state_d = WAIT;
                drop_d  = 1'b1;
            end
        end else begin
            case (state_q)
                REQ: if (imem_gnt) state_d = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else if (can_load) begin
                            fd_d    = '{valid: 1'b1, instr: imem_rdata, pc: pc_next};
                            pc_d    = pc_next;
                            state_d = REQ;
                        end else begin
                            hb_load = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!ctrl.stall && hb_valid) begin
                        fd_d     = '{valid: 1'b1, instr: hb_data, pc: pc_next};
                        pc_d     = pc_next;
                        hb_drain = 1'b1;
                        state_d  = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            fd_q    <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            fd_q    <= fd_d;
        end
    end

    fetch_hold_buffer u_hold (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .clear_i (hb_clear),
        .data_i  (imem_rdata),
        .valid_o (hb_valid),
        .data_o  (hb_data)
    );

    // Gated by reset so the request drops the instant reset is asserted.
    assign imem_req  = (state_q == REQ) && !reset;
    assign imem_addr = align_pc(pc_q);
    assign out_valid = fd_q.valid;
    assign out_instr = fd_q.instr;
    assign out_pc    = fd_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, back-to-back fetch, stall/hold, redirects, PC wrap, async reset.
module tb_fetch_stage;

    localparam logic [31:0] D1   = 32'h2008_0005;
    localparam logic [31:0] D2   = 32'h0001_0113;
    localparam logic [31:0] D3   = 32'h0042_8293;
    localparam logic [31:0] D4   = 32'h00A0_0513;
    localparam logic [31:0] D5   = 32'hFFF0_0093;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset, stall, redirect_valid, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_instr, out_pc;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_load(input string tag, input logic [31:0] pc);
        logic [31:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, e);
        check({tag, "_pc"}, out_pc, pc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        check("rst_req",   {31'b0, imem_req},  32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc",    out_pc,    32'h0);

        // Immediate grant, response one cycle later.
        reset = 1'b0; #1;
        check("t1_req0",  {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        imem_gnt = 1'b1; tick();
        check("t1_wait_req", {31'b0, imem_req}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D1; exp_q.push_back(D1); tick();
        check_load("t1_a", 32'h4);
        check("t1_addr4", imem_addr, 32'h4);
        imem_rvalid = 1'b0; imem_gnt = 1'b1; tick();
        check("t1_gap_valid", {31'b0, out_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D2; exp_q.push_back(D2); tick();
        check_load("t1_b", 32'h8);
        check("t1_addr8", imem_addr, 32'h8);

        // Stall while the response arrives: parked in HOLD, F/D frozen.
        imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1; tick();
        check("t2_s0_instr", out_instr, D2);
        check("t2_s0_valid", {31'b0, out_valid}, 32'd1);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D3; exp_q.push_back(D3); tick();
        check("t2_s1_instr", out_instr, D2);
        check("t2_s1_req",   {31'b0, imem_req}, 32'd0);
        imem_rdata = JUNK; tick();
        check("t2_s2_instr", out_instr, D2);
        check("t2_s2_pc",    out_pc, 32'h8);
        check("t2_s2_req",   {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b0; tick();
        check("t2_s3_instr", out_instr, D2);
        check("t2_s3_req",   {31'b0, imem_req}, 32'd0);
        stall = 1'b0; tick();
        check_load("t2_rel", 32'hC);
        check("t2_req",  {31'b0, imem_req}, 32'd1);
        check("t2_addr", imem_addr, 32'hC);

        // Redirect while waiting: the late response must be dropped.
        imem_gnt = 1'b1; tick();
        check("t3_wait_valid", {31'b0, out_valid}, 32'd0);
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; tick();
        check("t3_redir_req", {31'b0, imem_req}, 32'd0);
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = JUNK; tick();
        check("t3_drop_valid", {31'b0, out_valid}, 32'd0);
        check("t3_drop_instr", out_instr, 32'h0);
        check("t3_req",        {31'b0, imem_req}, 32'd1);
        check("t3_addr",       imem_addr, 32'h40);

        // Redirect and stall together with a live F/D entry.
        imem_rvalid = 1'b0; imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D4; exp_q.push_back(D4); tick();
        check_load("t4_a", 32'h44);
        imem_rvalid = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; tick();
        check("t4_valid", {31'b0, out_valid}, 32'd0);
        check("t4_instr", out_instr, 32'h0);
        check("t4_req",   {31'b0, imem_req}, 32'd1);
        check("t4_addr",  imem_addr, 32'h100);
        stall = 1'b0; redirect_valid = 1'b0;

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; tick();
        redirect_valid = 1'b0;
        check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D5; exp_q.push_back(D5); tick();
        check_load("t5_wrap", 32'h0);
        check("t5_addr0", imem_addr, 32'h0);
        imem_rvalid = 1'b0; imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = D1; exp_q.push_back(D1); tick();
        check_load("t6_setup", 32'h4);

        // Asynchronous reset in the middle of WAIT.
        imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1; tick();
        check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
        imem_gnt = 1'b0; reset = 1'b1; #1;
        check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_instr", out_instr, 32'h0);
        check("t6_rst_req",   {31'b0, imem_req}, 32'd0);
        check("t6_rst_pc",    out_pc, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = JUNK; stall = 1'b0; tick();
        reset = 1'b0; #1;
        check("t6_req",  {31'b0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);
        tick();
        check("t6_late_valid", {31'b0, out_valid}, 32'd0);
        check("t6_late_req",   {31'b0, imem_req}, 32'd1);
        check("t6_late_addr",  imem_addr, 32'h0);
        imem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
